// File: rtl/fp_to_int_pipe.sv
// Pipelined IEEE-754 single to W-bit integer converter: four rounding modes, saturating results, IEEE flags.
// Latency 3, throughput 1; the whole pipe stalls together while out_valid is held by ~out_ready.
module fp_to_int_pipe #(
  parameter int OUT_WIDTH  = 32,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic [1:0]           in_rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_invalid,
  output logic                 out_inexact
);
  localparam int         W        = OUT_WIDTH;
  localparam int         FXW      = W + 24;
  localparam logic [7:0] EXP_OVF  = 8'(127 + W);
  localparam logic [W:0] MAG_HALF = {2'b01, {(W-1){1'b0}}};
  localparam logic [W:0] MAG_SMAX = {2'b00, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RZ  = 2'd1,
    RM_RP  = 2'd2,
    RM_RM  = 2'd3
  } rm_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        zero;
    logic        den;
    logic        inf;
    logic        nan;
    rm_t         rm;
  } s1_t;

  typedef struct packed {
    logic       sign;
    logic       nan;
    logic       ovf;
    logic [W:0] mag;
    logic       rnd;
    logic       sticky;
    rm_t        rm;
  } s2_t;

  s1_t            s1_d, s1_q;
  s2_t            s2_d, s2_q;
  logic           v1, v2;
  logic [7:0]     sh;
  logic [FXW-1:0] fx;
  logic           inc;
  logic [W:0]     rounded;
  logic [W-1:0]   neg_mag;
  logic [W-1:0]   res;
  logic           ovf, unf, inv, inx;

  assign in_ready = ~(out_valid & ~out_ready);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_data[31];
    s1_d.exp  = in_data[30:23];
    s1_d.man  = {(in_data[30:23] != 8'd0), in_data[22:0]};
    s1_d.zero = (in_data[30:23] == 8'd0)  && (in_data[22:0] == 23'd0);
    s1_d.den  = (in_data[30:23] == 8'd0)  && (in_data[22:0] != 23'd0);
    s1_d.inf  = (in_data[30:23] == 8'hFF) && (in_data[22:0] == 23'd0);
    s1_d.nan  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    s1_d.rm   = rm_t'(in_rm);
  end

  // fx holds the value with 24 fraction bits: integer part above bit 24, round bit 23, sticky below.
  always_comb begin
    sh          = s1_q.exp - 8'd126;
    fx          = {{W{1'b0}}, s1_q.man} << sh;
    s2_d        = '0;
    s2_d.sign   = s1_q.sign;
    s2_d.nan    = s1_q.nan;
    s2_d.rm     = s1_q.rm;
    s2_d.ovf    = ~s1_q.nan & (s1_q.inf | (s1_q.exp >= EXP_OVF));
    if (!(s1_q.zero | s1_q.nan | s2_d.ovf)) begin
      if (s1_q.den || (s1_q.exp < 8'd126)) begin
        s2_d.sticky = 1'b1;
      end else begin
        s2_d.mag    = {1'b0, fx[FXW-1:24]};
        s2_d.rnd    = fx[23];
        s2_d.sticky = |fx[22:0];
      end
    end
  end

  always_comb begin
    inc = 1'b0;
    case (s2_q.rm)
      RM_RNE: inc = s2_q.rnd & (s2_q.sticky | s2_q.mag[0]);
      RM_RZ:  inc = 1'b0;
      RM_RP:  inc = ~s2_q.sign & (s2_q.rnd | s2_q.sticky);
      RM_RM:  inc = s2_q.sign & (s2_q.rnd | s2_q.sticky);
    endcase
    rounded = s2_q.mag + {{W{1'b0}}, inc};
    neg_mag = {W{1'b0}} - rounded[W-1:0];
    res     = '0;
    ovf     = 1'b0;
    unf     = 1'b0;
    inv     = 1'b0;
    if (s2_q.nan) begin
      inv = 1'b1;
    end else if (SIGNED_OUT) begin
      // A magnitude of exactly 2^(W-1) only fits as the most negative value.
      if (!s2_q.sign) begin
        if (s2_q.ovf || (rounded > MAG_SMAX)) begin
          res = {1'b0, {(W-1){1'b1}}};
          ovf = 1'b1;
        end else begin
          res = rounded[W-1:0];
        end
      end else begin
        if (s2_q.ovf || (rounded > MAG_HALF)) begin
          res = {1'b1, {(W-1){1'b0}}};
          unf = 1'b1;
        end else begin
          res = neg_mag;
        end
      end
    end else begin
      if (!s2_q.sign) begin
        if (s2_q.ovf || rounded[W]) begin
          res = '1;
          ovf = 1'b1;
        end else begin
          res = rounded[W-1:0];
        end
      end else if (s2_q.ovf || (rounded != '0)) begin
        unf = 1'b1;
      end
    end
    inx = (s2_q.rnd | s2_q.sticky) & ~ovf & ~unf & ~inv;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      s1_q          <= '0;
      s2_q          <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_invalid   <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (in_ready) begin
      v1            <= in_valid;
      s1_q          <= s1_d;
      v2            <= v1;
      s2_q          <= s2_d;
      out_valid     <= v2;
      out_data      <= res;
      out_overflow  <= ovf;
      out_underflow <= unf;
      out_invalid   <= inv;
      out_inexact   <= inx;
    end
  end

endmodule
